tt_uart_rx: RTL and testbench

- UART receiver on a Tiny Tapeout input pin: 8N1 frames arrive serially and are presented as bytes on a valid/ready interface.
- Input-direction counterpart to the byte-output path of the top-level tile.
- Sits between a ui_in bit and the core logic; the top level selects which pin drives rx_i.

---
 rtl/tt_uart_pkg.sv | 18 +
 rtl/tt_sync2.sv | 27 ++
 rtl/tt_uart_rx.sv | 215 +++++++++++++++++++++
 tb/tb_tt_uart_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the tt_uart_rx receiver.
package tt_uart_pkg;

   // Data bits per frame (8N1, or 8E1 with parity enabled).
   localparam int unsigned DATA_BITS = 8;

   // Below this the half-bit start check leaves no usable margin.
   localparam int unsigned MIN_CLKS_PER_BIT = 4;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } state_e;

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module tt_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture; the first stage may go metastable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/tt_uart_rx.sv
// UART receiver: 8N1 frames from an async pin to a one-byte valid/ready holding register.
// Optional even parity (8E1) with parity_err_o when TT_UART_RX_PARITY_EN is defined.
module tt_uart_rx
   import tt_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       overrun_o
`ifdef TT_UART_RX_PARITY_EN
   ,
   output logic       parity_err_o
`endif
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   if (CLKS_PER_BIT < MIN_CLKS_PER_BIT || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cfg
      $error("tt_uart_rx: CLKS_PER_BIT must be even and at least %0d", MIN_CLKS_PER_BIT);
   end

   logic                 w_rx_s;
   logic                 r_rx_prev;
   state_e               r_state;
   state_e               w_state_nxt;
   logic [CNT_W-1:0]     r_timer;
   logic [CNT_W-1:0]     w_timer_nxt;
   logic [2:0]           r_bit_idx;
   logic [2:0]           w_bit_idx_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_tick;
   logic                 w_deliver;
   logic                 w_frame_err;
   logic [7:0]           r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
`ifdef TT_UART_RX_PARITY_EN
   logic                 r_par_bad;
   logic                 w_par_bad_nxt;
   logic                 w_par_err;
   logic                 r_par_err;
`endif

   tt_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (rx_i),
      .o_q (w_rx_s)
   );

   // Delayed copy of the synchronized line for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_prev <= w_rx_s;
      end
   end

   assign w_tick = (r_timer == '0);

   // Frame FSM next-state: bit timer, bit index, shift register and delivery decision.
   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_deliver     = 1'b0;
      w_frame_err   = 1'b0;
`ifdef TT_UART_RX_PARITY_EN
      w_par_bad_nxt = r_par_bad;
      w_par_err     = 1'b0;
`endif
      if (r_state != StIdle && !w_tick) begin
         w_timer_nxt = r_timer - 1'b1;
      end
      unique case (r_state)
         StIdle: begin
            // Only a genuine 1->0 edge starts a frame; a stuck-low line never does.
            if (r_rx_prev && !w_rx_s) begin
               w_state_nxt = StStart;
               w_timer_nxt = HALF_LOAD;
            end
         end
         StStart: begin
            if (w_tick) begin
               if (w_rx_s) begin
                  w_state_nxt = StIdle;
               end else begin
                  w_state_nxt   = StData;
                  w_timer_nxt   = FULL_LOAD;
                  w_bit_idx_nxt = '0;
               end
            end
         end
         StData: begin
            if (w_tick) begin
               w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
               w_timer_nxt   = FULL_LOAD;
               w_bit_idx_nxt = r_bit_idx + 1'b1;
               if (r_bit_idx == LAST_IDX) begin
`ifdef TT_UART_RX_PARITY_EN
                  w_state_nxt = StParity;
`else
                  w_state_nxt = StStop;
`endif
               end
            end
         end
`ifdef TT_UART_RX_PARITY_EN
         StParity: begin
            if (w_tick) begin
               // Even parity: data bits plus parity bit must XOR to zero.
               w_par_bad_nxt = ^{r_shift, w_rx_s};
               w_timer_nxt   = FULL_LOAD;
               w_state_nxt   = StStop;
            end
         end
`endif
         StStop: begin
            if (w_tick) begin
               w_state_nxt = StIdle;
               // Framing error wins over a parity error.
               if (!w_rx_s) begin
                  w_frame_err = 1'b1;
`ifdef TT_UART_RX_PARITY_EN
               end else if (r_par_bad) begin
                  w_par_err = 1'b1;
`endif
               end else begin
                  w_deliver = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Frame FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_timer   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
`ifdef TT_UART_RX_PARITY_EN
         r_par_bad <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
`ifdef TT_UART_RX_PARITY_EN
         r_par_bad <= w_par_bad_nxt;
`endif
      end
   end

   // Holding register, handshake and one-cycle status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data      <= 8'h00;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef TT_UART_RX_PARITY_EN
         r_par_err   <= 1'b0;
`endif
      end else begin
         r_frame_err <= w_frame_err;
         r_overrun   <= 1'b0;
`ifdef TT_UART_RX_PARITY_EN
         r_par_err   <= w_par_err;
`endif
         if (w_deliver) begin
            // Slot is free, or is being drained in this very cycle.
            if (!r_valid || ready_i) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign busy_o      = (r_state != StIdle);
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;
`ifdef TT_UART_RX_PARITY_EN
   assign parity_err_o = r_par_err;
`endif

endmodule

// File: tb/tb_tt_uart_rx.sv
// Directed bench for tt_uart_rx with a byte scoreboard and pulse counters.
module tb_tt_uart_rx;

   localparam int CLKS = 16;
`ifdef TT_UART_RX_PARITY_EN
   localparam int SLOTS = 10;
`else
   localparam int SLOTS = 9;
`endif
   // Cycles from the driven start-bit change to valid_o, and busy_o high cycles per frame.
   localparam int LAT      = CLKS / 2 + SLOTS * CLKS + 3;
   localparam int BUSY_CYC = CLKS / 2 + SLOTS * CLKS;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       ready;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       ferr;
   logic       ovr;
   logic       perr;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_vhigh = 0;
   int n_ferr  = 0;
   int n_ovr   = 0;
   int n_perr  = 0;
   int n_busy  = 0;
   int t_rise  = -1;
   logic valid_d = 1'b0;
   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   tt_uart_rx #(
      .CLKS_PER_BIT (CLKS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx),
      .data_o       (data),
      .valid_o      (valid),
      .ready_i      (ready),
      .busy_o       (busy),
      .frame_err_o  (ferr),
      .overrun_o    (ovr)
`ifdef TT_UART_RX_PARITY_EN
      ,
      .parity_err_o (perr)
`endif
   );

`ifndef TT_UART_RX_PARITY_EN
   assign perr = 1'b0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor on the falling edge: scoreboard pops and pulse counting.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (valid) n_vhigh++;
            if (valid && !valid_d) t_rise = cyc;
            if (ferr) n_ferr++;
            if (ovr) n_ovr++;
            if (perr) n_perr++;
            if (busy) n_busy++;
            if (ferr || ovr || perr) begin
               check("flags_exclusive", 32'({1'b0, ferr} + {1'b0, ovr} + {1'b0, perr}), 32'd1);
            end
            if (valid && ready) begin
               if (sb_q.size() == 0) begin
                  check("sb_unexpected_byte", 32'(data), 32'hFFFF_FFFF);
               end else begin
                  check("sb_data", 32'(data), 32'(sb_q.pop_front()));
               end
            end
         end
         valid_d = valid;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Drive one frame; the line is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                             output int t0);
      @(posedge clk);
      #1 rx = 1'b0;
      t0 = cyc;
      wait_cyc(CLKS);
      for (int i = 0; i < 8; i++) begin
         #1 rx = d[i];
         wait_cyc(CLKS);
      end
`ifdef TT_UART_RX_PARITY_EN
      #1 rx = (^d) ^ par_flip;
      wait_cyc(CLKS);
`else
      if (par_flip) $display("[TB] parity flip ignored in 8N1 build");
`endif
      #1 rx = stop_bit;
      wait_cyc(CLKS);
   endtask

   initial begin
      int t0;
      int b_v, b_f, b_o, b_p, b_b;
      logic [7:0] pd;

      rx = 1'b1;
      ready = 1'b1;
      rst = 1'b1;
      wait_cyc(3);
      #1;
      check("rst_data", 32'(data), 32'h00);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ferr", 32'(ferr), 32'd0);
      check("rst_ovr", 32'(ovr), 32'd0);
      check("rst_perr", 32'(perr), 32'd0);
      rst = 1'b0;
      wait_cyc(5);

      // Plain byte delivery with latency and busy window.
      b_v = n_vhigh; b_f = n_ferr; b_o = n_ovr; b_b = n_busy;
      sb_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0, t0);
      wait_cyc(5);
      #1;
      check("a5_latency", 32'(t_rise - t0), 32'(LAT));
      check("a5_valid_cycles", 32'(n_vhigh - b_v), 32'd1);
      check("a5_busy_cycles", 32'(n_busy - b_b), 32'(BUSY_CYC));
      check("a5_busy_after", 32'(busy), 32'd0);
      check("a5_sb_empty", 32'(sb_q.size()), 32'd0);
      check("a5_no_flags", 32'(n_ferr - b_f + n_ovr - b_o), 32'd0);

      // False start: short low glitch.
      b_v = n_vhigh; b_f = n_ferr; b_o = n_ovr; b_b = n_busy;
      @(posedge clk);
      #1 rx = 1'b0;
      wait_cyc(4);
      #1 rx = 1'b1;
      wait_cyc(30);
      #1;
      check("glitch_busy_cycles", 32'(n_busy - b_b), 32'(CLKS / 2));
      check("glitch_no_valid", 32'(n_vhigh - b_v), 32'd0);
      check("glitch_no_flags", 32'(n_ferr - b_f + n_ovr - b_o), 32'd0);
      check("glitch_idle", 32'(busy), 32'd0);

      // Framing error, then line held low.
      b_v = n_vhigh; b_f = n_ferr; b_b = n_busy;
      send_frame(8'h3C, 1'b0, 1'b0, t0);
      wait_cyc(3 * SLOTS * CLKS);
      #1;
      check("ferr_pulses", 32'(n_ferr - b_f), 32'd1);
      check("ferr_no_valid", 32'(n_vhigh - b_v), 32'd0);
      check("ferr_no_new_frame", 32'(n_busy - b_b), 32'(BUSY_CYC));
      check("ferr_idle", 32'(busy), 32'd0);
      rx = 1'b1;
      wait_cyc(20);

      // Overrun: two back-to-back frames with no consumer.
      b_o = n_ovr;
      #1 ready = 1'b0;
      sb_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b0, t0);
      send_frame(8'h22, 1'b1, 1'b0, t0);
      wait_cyc(5);
      #1;
      check("ovr_pulses", 32'(n_ovr - b_o), 32'd1);
      check("ovr_data_kept", 32'(data), 32'h11);
      check("ovr_valid_held", 32'(valid), 32'd1);
      ready = 1'b1;
      wait_cyc(2);
      #1;
      check("ovr_valid_cleared", 32'(valid), 32'd0);
      check("ovr_sb_empty", 32'(sb_q.size()), 32'd0);

      // Reset in the middle of data bit 4, with a byte already held.
      ready = 1'b0;
      send_frame(8'h33, 1'b1, 1'b0, t0);
      wait_cyc(3);
      #1;
      check("mid_pre_valid", 32'(valid), 32'd1);
      pd = 8'h5A;
      @(posedge clk);
      #1 rx = 1'b0;
      wait_cyc(CLKS);
      for (int i = 0; i < 4; i++) begin
         #1 rx = pd[i];
         wait_cyc(CLKS);
      end
      #1 rx = pd[4];
      wait_cyc(CLKS / 2);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(valid), 32'd0);
      check("mid_rst_data", 32'(data), 32'h00);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_flags", 32'({ferr, ovr, perr}), 32'd0);
      @(posedge clk);
      #1 rx = 1'b1;
      rst = 1'b0;
      ready = 1'b1;
      wait_cyc(20);
      sb_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0, t0);
      wait_cyc(5);
      #1;
      check("post_rst_latency", 32'(t_rise - t0), 32'(LAT));
      check("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);

`ifdef TT_UART_RX_PARITY_EN
      // Even parity good, parity bad, and both parity and stop bad.
      b_v = n_vhigh; b_f = n_ferr; b_p = n_perr;
      sb_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0, t0);
      wait_cyc(5);
      #1;
      check("par_ok_delivered", 32'(n_vhigh - b_v), 32'd1);
      check("par_ok_sb_empty", 32'(sb_q.size()), 32'd0);
      b_v = n_vhigh;
      send_frame(8'h07, 1'b1, 1'b1, t0);
      wait_cyc(5);
      #1;
      check("par_bad_pulse", 32'(n_perr - b_p), 32'd1);
      check("par_bad_no_valid", 32'(n_vhigh - b_v), 32'd0);
      b_p = n_perr;
      send_frame(8'h07, 1'b0, 1'b1, t0);
      wait_cyc(5);
      #1;
      check("par_ferr_wins_f", 32'(n_ferr - b_f), 32'd1);
      check("par_ferr_wins_p", 32'(n_perr - b_p), 32'd0);
      rx = 1'b1;
      wait_cyc(20);
`else
      b_p = n_perr;
      check("no_parity_pulses", 32'(b_p), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
